// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate, direct-mapped data cache with a single-word backing memory port.
// Hits complete in the request cycle; misses run an optional 4-beat victim writeback, then a 4-beat fill.
module dcache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 13 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WB, FILL} stateT;

    stateT                state, nextState;
    logic [1:0]           beat;
    logic                 missed;
    logic [12:0]          missLine;

    logic [TAG_BITS-1:0]  tagArr  [LINES];
    logic [15:0]          dataArr [LINES][4];
    logic [LINES-1:0]     validArr;
    logic [LINES-1:0]     dirtyArr;

    logic [INDEX_BITS-1:0] reqIdx, missIdx;
    logic [TAG_BITS-1:0]   reqTag, missTag;
    logic [1:0]            reqOff;
    logic                  reqErr, hit, lastBeat, hitDone, missStart, fillLast;

    assign reqIdx   = Addr[3+INDEX_BITS-1:3];
    assign reqTag   = Addr[15:3+INDEX_BITS];
    assign reqOff   = Addr[2:1];
    assign missIdx  = missLine[INDEX_BITS-1:0];
    assign missTag  = missLine[12:INDEX_BITS];
    assign reqErr   = (Rd & Wr) | (Addr[0] & (Rd | Wr));
    assign hit      = validArr[reqIdx] & (tagArr[reqIdx] == reqTag);
    assign lastBeat = (beat == 2'd3);
    assign fillLast = (state == FILL) & mem_ack & lastBeat;

    // Next-state and all outputs are combinational; the retry after a fill completes through IDLE
    always_comb begin
        nextState = state;
        Done      = 1'b0;
        Stall     = 1'b0;
        CacheHit  = 1'b0;
        err       = 1'b0;
        DataOut   = 16'h0000;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        hitDone   = 1'b0;
        missStart = 1'b0;
        case (state)
            IDLE: begin
                if (Rd | Wr) begin
                    if (reqErr) begin
                        err  = 1'b1;
                        Done = 1'b1;
                    end else if (hit) begin
                        Done     = 1'b1;
                        CacheHit = ~missed;
                        hitDone  = 1'b1;
                        if (Rd)
                            DataOut = dataArr[reqIdx][reqOff];
                    end else begin
                        Stall     = 1'b1;
                        missStart = 1'b1;
                        nextState = (validArr[reqIdx] & dirtyArr[reqIdx]) ? WB : FILL;
                    end
                end
            end
            WB: begin
                Stall     = 1'b1;
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {tagArr[missIdx], missIdx, beat, 1'b0};
                mem_wdata = dataArr[missIdx][beat];
                if (mem_ack & lastBeat)
                    nextState = FILL;
            end
            FILL: begin
                Stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {missTag, missIdx, beat, 1'b0};
                if (mem_ack & lastBeat)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        err = err | (mem_ack & ~mem_req);
    end

    // Control state and line status; a reset mid-transfer leaves the line invalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= 2'd0;
            missed   <= 1'b0;
            missLine <= 13'd0;
            validArr <= '0;
            dirtyArr <= '0;
        end else begin
            state <= nextState;
            if (missStart) begin
                missed   <= 1'b1;
                missLine <= Addr[15:3];
                beat     <= 2'd0;
            end
            if (hitDone)
                missed <= 1'b0;
            if (hitDone & Wr)
                dirtyArr[reqIdx] <= 1'b1;
            if ((state != IDLE) & mem_ack)
                beat <= beat + 2'd1;
            if (fillLast) begin
                validArr[missIdx] <= 1'b1;
                dirtyArr[missIdx] <= 1'b0;
            end
        end
    end

    // Tag and data storage are deliberately not reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (hitDone & Wr)
            dataArr[reqIdx][reqOff] <= DataIn;
        if ((state == FILL) & mem_ack)
            dataArr[missIdx][beat] <= mem_rdata;
        if (fillLast)
            tagArr[missIdx] <= missTag;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table-driven single-cycle vectors, hand-written miss
// sequences, and a random load/store run against a flat-memory reference.
module tb_dcache_ctrl;

    logic        clk, rst;
    logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
    logic        Rd, Wr, Done, Stall, CacheHit, err, mem_req, mem_wr, mem_ack;
    logic        respAck, manualAck;

    int total = 0;
    int bad   = 0;

    int fixedLat;
    bit randLat;
    int reqCycles;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } beatT;
    beatT beatLog[$];

    logic [15:0] backMem [512];
    logic [15:0] refMem  [512];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        expDone;
        logic        expHit;
        logic        expErr;
        logic [15:0] expData;
    } vecT;
    vecT vecs [9];

    assign mem_ack = respAck | manualAck;

    dcache_ctrl #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] initVal(int w);
        return 16'(w * 311 + 16'h2B00);
    endfunction

    // Backing memory: each beat lasts beatLat cycles, ack raised on the negedge of its last cycle
    initial begin
        int waitCnt;
        int beatLat;
        for (int i = 0; i < 512; i++) backMem[i] = initVal(i);
        respAck   = 1'b0;
        mem_rdata = 16'h0000;
        waitCnt   = 0;
        beatLat   = 1;
        forever begin
            @(negedge clk or posedge rst);
            respAck = 1'b0;
            if (rst) begin
                waitCnt = 0;
            end else if (mem_req) begin
                if (waitCnt == 0) beatLat = randLat ? int'($urandom_range(1, 5)) : fixedLat;
                waitCnt++;
                if (waitCnt >= beatLat) begin
                    respAck = 1'b1;
                    waitCnt = 0;
                    if (mem_wr) backMem[mem_addr[9:1]] = mem_wdata;
                    else        mem_rdata = backMem[mem_addr[9:1]];
                    beatLog.push_back('{wr: mem_wr, addr: mem_addr, data: mem_wr ? mem_wdata : mem_rdata});
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    initial begin
        reqCycles = 0;
        forever begin
            @(negedge clk);
            if (mem_req) reqCycles++;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Holds a request until Done (bounded), counting stalled cycles; returns at posedge+1
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] din, output int stallCyc, output logic doneSeen,
                                 output logic hitOut, output logic [15:0] dataOut);
        Rd = rd; Wr = wr; Addr = addr; DataIn = din;
        stallCyc = 0; doneSeen = 1'b0; hitOut = 1'b0; dataOut = 16'h0000;
        for (int c = 0; c < 300 && !doneSeen; c++) begin
            @(negedge clk);
            if (Done) begin
                doneSeen = 1'b1;
                hitOut   = CacheHit;
                dataOut  = DataOut;
            end else if (Stall) begin
                stallCyc++;
            end
            @(posedge clk); #1;
        end
        Rd = 1'b0; Wr = 1'b0;
    endtask

    initial begin
        int          stallCyc, startIdx, reqBefore, nWr;
        logic        doneSeen, hitOut, found;
        logic [15:0] dOut;

        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
        manualAck = 1'b0; fixedLat = 1; randLat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkBit("rstDone", Done, 1'b0);
        checkBit("rstStall", Stall, 1'b0);
        checkBit("rstErr", err, 1'b0);
        checkBit("rstHit", CacheHit, 1'b0);
        checkBit("rstReq", mem_req, 1'b0);
        checkOutput("rstMemAddr", mem_addr, 16'h0000);
        checkOutput("rstDataOut", DataOut, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] clean miss fill");
        startIdx = beatLog.size();
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, stallCyc, doneSeen, hitOut, dOut);
        checkBit("t1Done", doneSeen, 1'b1);
        checkOutput("t1Stall", 16'(stallCyc), 16'd5);
        checkBit("t1Hit", hitOut, 1'b0);
        checkOutput("t1Data", dOut, initVal(8));
        checkOutput("t1Beats", 16'(beatLog.size() - startIdx), 16'd4);
        for (int k = 0; k < 4 && startIdx + k < beatLog.size(); k++) begin
            checkBit("t1BeatWr", beatLog[startIdx + k].wr, 1'b0);
            checkOutput("t1BeatAddr", beatLog[startIdx + k].addr, 16'(16'h0010 + 2 * k));
        end

        $display("[TB] store hit");
        reqBefore = reqCycles;
        applyStimulus(1'b0, 1'b1, 16'h0012, 16'hBEEF, stallCyc, doneSeen, hitOut, dOut);
        checkBit("t2Done", doneSeen, 1'b1);
        checkOutput("t2Stall", 16'(stallCyc), 16'd0);
        checkBit("t2Hit", hitOut, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0000, stallCyc, doneSeen, hitOut, dOut);
        checkOutput("t2Data", dOut, 16'hBEEF);
        checkBit("t2LoadHit", hitOut, 1'b1);

        vecs[0] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 16'h0014, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0014, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0, initVal(8)};
        vecs[4] = '{1'b1, 1'b1, 16'h0010, 16'hDEAD, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 16'h0011, 16'hDEAD, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[7] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0, initVal(8)};
        vecs[8] = '{1'b0, 1'b0, 16'h0016, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        for (int v = 0; v < 9; v++) begin
            Rd = vecs[v].rd; Wr = vecs[v].wr; Addr = vecs[v].addr; DataIn = vecs[v].din;
            @(negedge clk);
            checkBit($sformatf("vec%0dDone", v), Done, vecs[v].expDone);
            checkBit($sformatf("vec%0dHit", v), CacheHit, vecs[v].expHit);
            checkBit($sformatf("vec%0dErr", v), err, vecs[v].expErr);
            checkBit($sformatf("vec%0dStall", v), Stall, 1'b0);
            checkOutput($sformatf("vec%0dData", v), DataOut, vecs[v].expData);
            @(posedge clk); #1;
        end
        Rd = 1'b0; Wr = 1'b0;

        manualAck = 1'b1;
        @(negedge clk);
        checkBit("t5AckErr", err, 1'b1);
        @(posedge clk); #1;
        manualAck = 1'b0;
        @(negedge clk);
        checkBit("t5AckErrGone", err, 1'b0);
        checkBit("t5AckStall", Stall, 1'b0);
        checkOutput("t5NoReq", 16'(reqCycles - reqBefore), 16'd0);
        @(posedge clk); #1;

        $display("[TB] dirty miss writeback");
        startIdx = beatLog.size();
        applyStimulus(1'b1, 1'b0, 16'h0090, 16'h0000, stallCyc, doneSeen, hitOut, dOut);
        checkBit("t3Done", doneSeen, 1'b1);
        checkOutput("t3Stall", 16'(stallCyc), 16'd9);
        checkBit("t3Hit", hitOut, 1'b0);
        checkOutput("t3Data", dOut, initVal(72));
        checkOutput("t3Beats", 16'(beatLog.size() - startIdx), 16'd8);
        if (beatLog.size() - startIdx >= 8) begin
            checkOutput("t3Wb0", beatLog[startIdx].data, initVal(8));
            checkOutput("t3Wb1", beatLog[startIdx + 1].data, 16'hBEEF);
            checkOutput("t3Wb2", beatLog[startIdx + 2].data, 16'h1234);
            checkOutput("t3Wb3", beatLog[startIdx + 3].data, initVal(11));
            for (int k = 0; k < 8; k++) begin
                checkBit("t3BeatWr", beatLog[startIdx + k].wr, (k < 4) ? 1'b1 : 1'b0);
                checkOutput("t3BeatAddr", beatLog[startIdx + k].addr,
                            (k < 4) ? 16'(16'h0010 + 2 * k) : 16'(16'h0090 + 2 * (k - 4)));
            end
        end

        $display("[TB] reset during fill");
        applyStimulus(1'b0, 1'b1, 16'h0092, 16'h5555, stallCyc, doneSeen, hitOut, dOut);
        checkBit("t4StoreHit", hitOut, 1'b1);
        startIdx = beatLog.size();
        fixedLat = 3;
        Rd = 1'b1; Addr = 16'h0010;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (mem_req && !mem_wr && mem_addr == 16'h0014) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checkBit("t4FoundFillBeat2", found, 1'b1);
        #1;
        rst = 1'b1; Rd = 1'b0;
        #1;
        checkBit("t4ReqDrop", mem_req, 1'b0);
        checkBit("t4StallDrop", Stall, 1'b0);
        checkOutput("t4BeatsBefore", 16'(beatLog.size() - startIdx), 16'd6);
        if (beatLog.size() - startIdx >= 2) begin
            checkOutput("t4WbAddr", beatLog[startIdx + 1].addr, 16'h0092);
            checkOutput("t4WbData", beatLog[startIdx + 1].data, 16'h5555);
        end
        @(negedge clk); #1;
        rst = 1'b0; fixedLat = 1;
        @(posedge clk); #1;
        startIdx = beatLog.size();
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, stallCyc, doneSeen, hitOut, dOut);
        nWr = 0;
        for (int k = startIdx; k < beatLog.size(); k++) if (beatLog[k].wr) nWr++;
        checkBit("t4ReDone", doneSeen, 1'b1);
        checkOutput("t4ReWrBeats", 16'(nWr), 16'd0);
        checkOutput("t4ReBeats", 16'(beatLog.size() - startIdx), 16'd4);
        checkOutput("t4ReStall", 16'(stallCyc), 16'd5);
        checkBit("t4ReHit", hitOut, 1'b0);
        checkOutput("t4ReData", dOut, initVal(8));
        applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0000, stallCyc, doneSeen, hitOut, dOut);
        checkOutput("t4WrittenBack", dOut, 16'hBEEF);

        $display("[TB] random loads and stores");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 512; i++) refMem[i] = backMem[i];
        randLat = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [15:0] a, d;
            logic        isWr;
            a    = 16'($urandom_range(0, 511) << 1);
            d    = 16'($urandom);
            isWr = 1'($urandom_range(0, 1));
            applyStimulus(~isWr, isWr, a, d, stallCyc, doneSeen, hitOut, dOut);
            checkBit($sformatf("rnd%0dDone", n), doneSeen, 1'b1);
            if (isWr) refMem[a[9:1]] = d;
            else checkOutput($sformatf("rnd%0dLoad@%h", n, a), dOut, refMem[a[9:1]]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
